// File: rtl/reg_file_sb_if.sv
// Register file bus: read ports, two writeback ports, reservation request, busy count.
// Pure wiring bundle; no state and no latency of its own.
// No backpressure: every request on this bus is accepted in the cycle it is presented.
interface reg_file_sb_if #(
    parameter int N     = 32,
    parameter int WIDTH = 32,
    parameter int NR_RD = 2,
    parameter int AW    = $clog2(N)
);
    // Issue-side read ports
    logic [NR_RD*AW-1:0]    rd_addr;
    logic [NR_RD*WIDTH-1:0] rd_data;
    logic [NR_RD-1:0]       rd_busy;

    // Writeback port 0 (ALU path)
    logic                   we0;
    logic [AW-1:0]          wa0;
    logic [WIDTH-1:0]       wd0;

    // Writeback port 1 (load path, higher priority)
    logic                   we1;
    logic [AW-1:0]          wa1;
    logic [WIDTH-1:0]       wd1;

    // Scoreboard reservation from issue
    logic                   rsv_en;
    logic [AW-1:0]          rsv_addr;
    logic [AW:0]            busy_cnt;

    // Pipeline side: drives addresses, writes and reservations
    modport master (
        output rd_addr, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    // Register file side
    modport slave (
        input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port register file with two prioritised write ports, optional bypass and a busy scoreboard.
// Reads are combinational (0 cycles); writes, reservations and busy_cnt update on the next rising edge.
// No backpressure: reads, writes and reservations are always accepted.
module reg_file_sb #(
    parameter int N      = 32,
    parameter int WIDTH  = 32,
    parameter int NR_RD  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_sb_if.slave   bus
);

    logic [WIDTH-1:0] regs_q [N];
    logic [WIDTH-1:0] regs_d [N];
    logic [N-1:0]     busy_q;
    logic [N-1:0]     busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    logic [NR_RD*WIDTH-1:0] rd_data_c;
    logic [NR_RD-1:0]       rd_busy_c;

    // Register contents after this edge: port 0 first so port 1 overwrites on an address clash
    always_comb begin
        for (int i = 0; i < N; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (bus.we0 && (bus.wa0 != '0)) begin
            regs_d[bus.wa0] = bus.wd0;
        end
        if (bus.we1 && (bus.wa1 != '0)) begin
            regs_d[bus.wa1] = bus.wd1;
        end
        regs_d[0] = '0;
    end

    // Scoreboard after this edge: writebacks clear, a new reservation wins over a same-cycle write
    always_comb begin
        busy_d = busy_q;
        if (bus.we0) begin
            busy_d[bus.wa0] = 1'b0;
        end
        if (bus.we1) begin
            busy_d[bus.wa1] = 1'b0;
        end
        if (bus.rsv_en) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Population count of the next busy vector, registered so busy_cnt is a clean flop output
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    // State update; reset overrides any same-cycle write or reservation
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read ports: x0 is always zero/not-busy; a bypassed read also shows the post-edge busy bit
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NR_RD; k++) begin
            logic [AW-1:0] ra;
            logic          hit0;
            logic          hit1;
            ra   = bus.rd_addr[k*AW +: AW];
            hit0 = (BYPASS != 0) && bus.we0 && (bus.wa0 == ra);
            hit1 = (BYPASS != 0) && bus.we1 && (bus.wa1 == ra);
            if (ra == '0) begin
                rd_data_c[k*WIDTH +: WIDTH] = '0;
                rd_busy_c[k]                = 1'b0;
            end else if (hit1) begin
                rd_data_c[k*WIDTH +: WIDTH] = bus.wd1;
                rd_busy_c[k]                = busy_d[ra];
            end else if (hit0) begin
                rd_data_c[k*WIDTH +: WIDTH] = bus.wd0;
                rd_busy_c[k]                = busy_d[ra];
            end else begin
                rd_data_c[k*WIDTH +: WIDTH] = regs_q[ra];
                rd_busy_c[k]                = busy_q[ra];
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_cnt = busy_cnt_q;

endmodule
